// File: rtl/transciever_pkg.sv
// Shared definitions for the transceiver controllers: FSM state encoding,
// line idle level, default frame geometry and the effective bit-time rule.
package transciever_pkg;

    localparam int unsigned DEFAULT_DATA_BITS = 8;
    localparam int unsigned DEFAULT_STOP_BITS = 1;
    localparam int unsigned BIT_TIME_W        = 32;

    localparam logic LINE_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    // A programmed bit time of zero would stall the timer, so it runs as one cycle.
    function automatic logic [BIT_TIME_W-1:0] effective_bit_time(
        input logic [BIT_TIME_W-1:0] bit_time
    );
        return (bit_time == '0) ? BIT_TIME_W'(1) : bit_time;
    endfunction

endpackage

// File: rtl/transciever_tx_controller_if.sv
// Bus/FIFO/line bundle of the transmit controller.
//   master : bus interface + FIFO side (drives config, request, FIFO status/data)
//   slave  : transmit controller (drives pop strobe, serial line, busy status)
interface transciever_tx_controller_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [31:0]          bit_time;
    logic                 start_transmission;
    logic                 line_invert;
    logic                 transmit_fifo_has_data;
    logic [DATA_BITS-1:0] transmit_fifo_data;
    logic                 transmit_fifo_read;
    logic                 tx_line;
    logic                 transmission_in_progress;

    modport master (
        output bit_time,
        output start_transmission,
        output line_invert,
        output transmit_fifo_has_data,
        output transmit_fifo_data,
        input  transmit_fifo_read,
        input  tx_line,
        input  transmission_in_progress
    );

    modport slave (
        input  bit_time,
        input  start_transmission,
        input  line_invert,
        input  transmit_fifo_has_data,
        input  transmit_fifo_data,
        output transmit_fifo_read,
        output tx_line,
        output transmission_in_progress
    );

endinterface

// File: rtl/transciever_bit_timer.sv
// Bit-period down counter shared by the transmit and receive controllers.
//   clk, rst   : clock, async active-high reset
//   load       : restart the period with load_value (must be >= 1)
//   load_value : period length in clock cycles
//   bit_tick   : registered, high for the last cycle of every period
module transciever_bit_timer
    import transciever_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIT_TIME_W-1:0] load_value,
    output logic                  bit_tick
);

    logic [BIT_TIME_W-1:0] period;
    logic [BIT_TIME_W-1:0] count;
    logic [BIT_TIME_W-1:0] count_next;

    // Reload at 1 rather than wrapping through 0; a cleared timer stays parked at 0.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_value;
        end else if (count == BIT_TIME_W'(1)) begin
            count_next = period;
        end else if (count != '0) begin
            count_next = count - BIT_TIME_W'(1);
        end
    end

    // Tick is registered from the next count so it is high exactly while count == 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period   <= '0;
            count    <= '0;
            bit_tick <= 1'b0;
        end else begin
            if (load) begin
                period <= load_value;
            end
            count    <= count_next;
            bit_tick <= (count_next == BIT_TIME_W'(1));
        end
    end

endmodule

// File: rtl/transciever_tx_controller.sv
// Transmit sequencer: on a start request drains the transmit FIFO, sending
// each byte LSB-first as a start/data/stop frame on a registered serial line.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of transciever_tx_controller_if (config, request,
//              FIFO status/data in; FIFO pop, tx_line, busy status out)
module transciever_tx_controller
    import transciever_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
    parameter int unsigned STOP_BITS = DEFAULT_STOP_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    transciever_tx_controller_if.slave  bus
);

    localparam int unsigned BIT_CNT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned STOP_CNT_W = 2;

    tx_state_t              state;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [STOP_CNT_W-1:0]  stop_cnt;
    logic                   fifo_read;
    logic                   tx_line;
    logic                   in_progress;
    logic                   bit_tick;
    logic                   timer_load;
    logic                   line_level;

    // Bit time is latched once per frame, in LOAD.
    assign timer_load = (state == LOAD);

    transciever_bit_timer u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (effective_bit_time(bus.bit_time)),
        .bit_tick   (bit_tick)
    );

    // Uninverted line level for the current state; STOP uses the idle level.
    always_comb begin
        line_level = LINE_IDLE_LEVEL;
        case (state)
            START:   line_level = 1'b0;
            DATA:    line_level = shift_reg[0];
            default: line_level = LINE_IDLE_LEVEL;
        endcase
    end

    // Sequencer; line and busy flag follow the state one clock later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= '0;
            fifo_read   <= 1'b0;
            tx_line     <= LINE_IDLE_LEVEL;
            in_progress <= 1'b0;
        end else begin
            fifo_read   <= 1'b0;
            tx_line     <= line_level ^ bus.line_invert;
            in_progress <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.start_transmission && bus.transmit_fifo_has_data) begin
                        state     <= FETCH;
                        fifo_read <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= bus.transmit_fifo_data;
                    state     <= START;
                end
                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                            state    <= STOP;
                            stop_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (stop_cnt == STOP_CNT_W'(STOP_BITS - 1)) begin
                            if (bus.transmit_fifo_has_data) begin
                                state     <= FETCH;
                                fifo_read <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + STOP_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.transmit_fifo_read       = fifo_read;
    assign bus.tx_line                  = tx_line;
    assign bus.transmission_in_progress = in_progress;

endmodule

// File: tb/tb_transciever_tx_controller.sv
// Bench for transciever_tx_controller: a FIFO model feeds bytes, and a
// per-cycle expectation of line, busy flag and pop strobe is built from the
// frame rules (read one cycle before each 2-cycle lead-in, then the frame).
module tb_transciever_tx_controller;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef struct packed {
        logic line;
        logic tip;
        logic rd;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    transciever_tx_controller_if #(.DATA_BITS(DATA_BITS)) bus ();

    transciever_tx_controller #(
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FIFO model: written by stimulus at negedges, popped on the DUT strobe.
    logic [7:0]  fifo_mem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    assign bus.transmit_fifo_has_data = (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (bus.transmit_fifo_read && (wr_ptr != rd_ptr)) begin
            bus.transmit_fifo_data <= fifo_mem[rd_ptr % 256];
            rd_ptr                 <= rd_ptr + 1;
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   tip_cycles;
    logic [7:0]  burst_bytes [$];
    logic [31:0] burst_bt [$];
    cyc_t        exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr % 256] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic int eff_bt(input logic [31:0] bt);
        return (bt == 0) ? 1 : int'(bt);
    endfunction

    // Sends burst_bytes with per-frame bit times burst_bt and checks every cycle.
    task automatic run_burst(input logic inv, input int extra_start_at,
                             input int bt_change_at, input logic [31:0] bt_new,
                             input string tag);
        int   n;
        logic idle;
        logic bits [$];
        cyc_t c;

        n    = burst_bytes.size();
        idle = 1'b1 ^ inv;
        exp_q.delete();

        bus.line_invert = inv;
        bus.bit_time    = (n > 0) ? burst_bt[0] : 32'($urandom_range(0, 5));
        foreach (burst_bytes[k]) push_byte(burst_bytes[k]);
        @(negedge clk);
        @(negedge clk);

        if (n == 0) begin
            repeat (4) exp_q.push_back('{line: idle, tip: 1'b0, rd: 1'b0});
        end else begin
            exp_q.push_back('{line: idle, tip: 1'b0, rd: 1'b1});
            for (int k = 0; k < n; k++) begin
                repeat (2) exp_q.push_back('{line: idle, tip: 1'b1, rd: 1'b0});
                bits.delete();
                bits.push_back(1'b0);
                for (int b = 0; b < int'(DATA_BITS); b++) bits.push_back(burst_bytes[k][b]);
                for (int s = 0; s < int'(STOP_BITS); s++) bits.push_back(1'b1);
                foreach (bits[b]) begin
                    repeat (eff_bt(burst_bt[k]))
                        exp_q.push_back('{line: bits[b] ^ inv, tip: 1'b1, rd: 1'b0});
                end
                if (k < n - 1) begin
                    c = exp_q[exp_q.size() - 1];
                    c.rd = 1'b1;
                    exp_q[exp_q.size() - 1] = c;
                end
            end
            repeat (3) exp_q.push_back('{line: idle, tip: 1'b0, rd: 1'b0});
        end

        tip_cycles = 0;
        bus.start_transmission = 1'b1;
        @(negedge clk);
        bus.start_transmission = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq({tag, ".line"}, 32'(bus.tx_line), 32'(exp_q[i].line));
            check_eq({tag, ".busy"}, 32'(bus.transmission_in_progress), 32'(exp_q[i].tip));
            check_eq({tag, ".read"}, 32'(bus.transmit_fifo_read), 32'(exp_q[i].rd));
            if (bus.transmission_in_progress === 1'b1) tip_cycles++;
            bus.start_transmission = (i == extra_start_at);
            if (i == bt_change_at) bus.bit_time = bt_new;
            @(negedge clk);
        end
        bus.start_transmission = 1'b0;
        check_eq({tag, ".drained"}, 32'(bus.transmit_fifo_has_data), 32'd0);
        burst_bytes.delete();
        burst_bt.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] bt;

        rst                    = 1'b1;
        bus.bit_time           = 32'd4;
        bus.start_transmission = 1'b0;
        bus.line_invert        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset.line", 32'(bus.tx_line), 32'd1);
        check_eq("reset.busy", 32'(bus.transmission_in_progress), 32'd0);
        check_eq("reset.read", 32'(bus.transmit_fifo_read), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single 0xA5 frame at 4 cycles per bit; busy for 2 + 40 cycles.
        burst_bytes = '{8'hA5};
        burst_bt    = '{32'd4};
        run_burst(1'b0, -1, -1, 32'd0, "a5");
        check_eq("a5.busy_len", 32'(tip_cycles), 32'd42);

        // Back-to-back 0x00, 0xFF at 2 cycles per bit.
        burst_bytes = '{8'h00, 8'hFF};
        burst_bt    = '{32'd2, 32'd2};
        run_burst(1'b0, -1, -1, 32'd0, "b2b");

        // Request with an empty FIFO is ignored.
        run_burst(1'b0, -1, -1, 32'd0, "empty");

        // Extra request mid-frame produces no extra frame.
        burst_bytes = '{8'h3C};
        burst_bt    = '{32'd3};
        run_burst(1'b0, 10, -1, 32'd0, "midreq");

        // Inverted line, 0x0F at 1 cycle per bit.
        burst_bytes = '{8'h0F};
        burst_bt    = '{32'd1};
        run_burst(1'b1, -1, -1, 32'd0, "invert");

        // Zero bit time runs as one cycle per bit.
        burst_bytes = '{8'h96};
        burst_bt    = '{32'd0};
        run_burst(1'b0, -1, -1, 32'd0, "bt0");

        // Bit time rewritten mid-frame: current frame keeps 3, next uses 5.
        burst_bytes = '{8'h5A, 8'hC3};
        burst_bt    = '{32'd3, 32'd5};
        run_burst(1'b0, -1, 8, 32'd5, "btchg");

        // Reset asserted during DATA: byte lost, outputs return to reset values.
        bus.line_invert = 1'b0;
        bus.bit_time    = 32'd4;
        push_byte(8'h81);
        @(negedge clk);
        bus.start_transmission = 1'b1;
        @(negedge clk);
        bus.start_transmission = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rstmid.line", 32'(bus.tx_line), 32'd1);
        check_eq("rstmid.busy", 32'(bus.transmission_in_progress), 32'd0);
        check_eq("rstmid.read", 32'(bus.transmit_fifo_read), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("rstmid.hold_read", 32'(bus.transmit_fifo_read), 32'd0);
            check_eq("rstmid.hold_line", 32'(bus.tx_line), 32'd1);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("rstpost.line", 32'(bus.tx_line), 32'd1);
            check_eq("rstpost.busy", 32'(bus.transmission_in_progress), 32'd0);
            check_eq("rstpost.read", 32'(bus.transmit_fifo_read), 32'd0);
        end
        burst_bytes = '{8'hE7};
        burst_bt    = '{32'd2};
        run_burst(1'b0, -1, -1, 32'd0, "afterrst");

        // Randomized bursts.
        for (int it = 0; it < 10; it++) begin
            n  = int'($urandom_range(0, 3));
            bt = 32'($urandom_range(0, 5));
            for (int k = 0; k < n; k++) begin
                burst_bytes.push_back(8'($urandom));
                burst_bt.push_back(bt);
            end
            run_burst(1'($urandom_range(0, 1)), -1, -1, 32'd0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/transciever_tx_controller.md
# transciever_tx_controller

Transmit-side sequencer for the memory-mapped transceiver. On a `start_transmission` pulse from the bus interface it drains the transmit FIFO byte by byte. Each byte is serialized LSB-first as a start/data/stop frame on the line, and every bit lasts `bit_time` clock cycles. It also drives the `transmission_in_progress` status bit that software polls through the control/status register.

## Interface
- `DATA_BITS`, default 8: data bits per frame; also the FIFO data width.
- `STOP_BITS`, default 1: stop bits per frame (1 or 2).
- `clk` in 1: system clock; everything is on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `bit_time` in 32: clock cycles per bit; sampled at frame start.
- `start_transmission` in 1: one-cycle request pulse from the bus interface.
- `line_invert` in 1: inverts the serial output when 1; sampled continuously.
- `transmit_fifo_has_data` in 1: FIFO not empty.
- `transmit_fifo_data` in DATA_BITS: FIFO read data, valid the cycle after a read pulse.
- `transmit_fifo_read` out 1: one-cycle pop strobe.
- `tx_line` out 1: registered serial output.
- `transmission_in_progress` out 1: high while any frame is being fetched or sent.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: the line is at idle level (logic 1 before inversion).
  - `start_transmission` with `transmit_fifo_has_data`=1 moves to FETCH.
  - A start request while the FIFO is empty is ignored.
- FETCH (1 cycle): asserts `transmit_fifo_read`, then moves to LOAD.
- LOAD (1 cycle): captures `transmit_fifo_data` into the shift register, loads the bit timer with the effective bit time, then moves to START.
- START: drives the line 0 for one bit period, then DATA.
- DATA: shifts out DATA_BITS bits, LSB first, one bit period each. A bit counter runs 0..DATA_BITS-1. Then STOP.
- STOP: drives the line 1 for STOP_BITS bit periods.
  - If `transmit_fifo_has_data`=1, go to FETCH (continuous drain).
  - Otherwise go to IDLE.
- Effective bit time is `bit_time`, except `bit_time`=0 is treated as 1.
  - It is latched in LOAD, so a write to `bit_time` mid-frame takes effect on the next frame.
- `tx_line` is registered as line_level XOR `line_invert`. Inverting mid-frame takes effect on the next clock.
- `start_transmission` in any state other than IDLE is ignored. No request is queued.
- `transmission_in_progress` is 1 in every state except IDLE.
- Reset, including mid-frame: state IDLE, `tx_line`=1, `transmission_in_progress`=0, `transmit_fifo_read`=0, counters and shift register 0.
  - The byte being transmitted is lost. The FIFO is not touched.

## Timing
- Request at edge t (IDLE): FETCH during t..t+1, with `transmit_fifo_read` high for exactly that cycle.
- LOAD occupies t+1..t+2.
- `tx_line` goes to start level at edge t+3.
- Every bit lasts exactly the effective bit time in cycles.
- Frame length: (1+DATA_BITS+STOP_BITS)×bit_time cycles on the line.
- Gap between back-to-back frames: 2 idle-level cycles (FETCH and LOAD).
- `transmission_in_progress` rises at edge t+1. It falls on the edge where the last stop bit ends if the FIFO is empty.
- Bit timer: 32-bit down counter, reloaded at each bit boundary. It does not wrap: a reload happens when the count reaches 1.

## Structure
- Shared package `transciever_pkg`:
  - FSM state enum.
  - `LINE_IDLE_LEVEL`=1'b1.
  - Default DATA_BITS and STOP_BITS.
- Sub-module `transciever_bit_timer`:
  - Inputs: load value and load strobe.
  - Output: one-cycle `bit_tick` at each period end.
  - Reused later by the receive controller.

## Test plan
- bit_time=4, FIFO holds 0xA5, start pulse:
  - Expect one read strobe, then the line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, first bit at +3 cycles.
  - `transmission_in_progress` is high for 42 cycles.
- FIFO holds 0x00 and 0xFF, bit_time=2: two frames with exactly 2 idle-high cycles between them and two read strobes.
  - After the second frame, `transmission_in_progress` falls and the line stays 1.
- Start with the FIFO empty: no read strobe, the line stays 1, `transmission_in_progress` stays 0.
  - A second start pulse sent mid-frame: no extra frame.
- `line_invert`=1, byte 0x0F, bit_time=1: the output is the bitwise complement of the expected frame; idle level is 0.
- bit_time=0: each bit lasts 1 cycle.
  - Change bit_time from 3 to 5 mid-frame: the current frame stays at 3, the next frame uses 5.
- Assert `rst` during the DATA state: the line immediately goes to 1, all outputs reach reset values, and no read strobe occurs.
  - After release, a start request with the FIFO non-empty transmits normally.
